// File: rtl/ysyx_25050147_ifu.sv
// Instruction fetch unit: owns the PC, issues one imem read at a time and holds
// the fetched word until decode accepts it. Stops for good on ebreak or imem fault.
module ysyx_25050147_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  output logic        imem_rsp_ready,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_HALT} state_t;

  state_t state, state_nxt;
  logic   req_fire, rsp_fire, inst_fire;

  assign imem_req_valid = ~rst & (state == S_FETCH);
  assign imem_rsp_ready = ~rst & (state == S_WAIT);
  assign inst_valid     = ~rst & (state == S_HOLD);
  assign imem_req_addr  = pc;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign rsp_fire  = imem_rsp_valid & imem_rsp_ready;
  assign inst_fire = inst_valid & inst_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH: if (req_fire) state_nxt = S_WAIT;
      S_WAIT:  if (rsp_fire) state_nxt = imem_rsp_err ? S_HALT : S_HOLD;
      S_HOLD:  if (inst_fire) state_nxt = halt ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      inst     <= '0;
      inst_cnt <= '0;
      halted   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (rsp_fire) begin
        if (imem_rsp_err) begin
          fault  <= 1'b1;
          halted <= 1'b1;
        end else begin
          inst <= imem_rsp_data;
        end
      end
      // halt takes priority over a simultaneous redirect and freezes pc
      if (inst_fire) begin
        inst_cnt <= inst_cnt + 32'd1;
        if (halt)                halted <= 1'b1;
        else if (redirect_valid) pc <= redirect_pc & ~32'h3;
        else                     pc <= pc + 32'd4;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25050147_ifu.sv
// Directed bench for ysyx_25050147_ifu: inputs driven and outputs sampled 1 ns
// after each rising edge, expectations hand-computed per scenario.
module tb_ysyx_25050147_ifu;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid, imem_rsp_ready, imem_rsp_err;
  logic [31:0] imem_rsp_data;
  logic [31:0] inst;
  logic        inst_valid, inst_ready, halt, redirect_valid;
  logic [31:0] redirect_pc, pc, inst_cnt;
  logic        halted, fault;

  int unsigned vecs = 0;
  int unsigned errs = 0;

  ysyx_25050147_ifu #(.RESET_PC(32'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
    .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .halted(halted), .fault(fault), .inst_cnt(inst_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    imem_req_ready = 0; imem_rsp_valid = 0; imem_rsp_err = 0; imem_rsp_data = '0;
    inst_ready = 0; halt = 0; redirect_valid = 0; redirect_pc = '0;
  endtask

  // Stimulus only: from FETCH, accept request then return data; ends in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_data = data; tick(); imem_rsp_valid = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1; tick();
    vecs++; if ({imem_req_valid, imem_rsp_ready, inst_valid} !== 3'b000) begin
      errs++; $display("FAIL reset_valids got %b exp 000", {imem_req_valid, imem_rsp_ready, inst_valid}); end
    vecs++; if (pc !== 32'h8000_0000 || inst !== 32'h0 || inst_cnt !== 32'h0) begin
      errs++; $display("FAIL reset_regs got pc=%h inst=%h cnt=%h exp 80000000/0/0", pc, inst, inst_cnt); end
    vecs++; if ({halted, fault} !== 2'b00) begin
      errs++; $display("FAIL reset_flags got %b exp 00", {halted, fault}); end
    rst = 0; #1;
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errs++; $display("FAIL first_req got v=%b a=%h exp 1/80000000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_zero_latency();
    logic [31:0] words [3];
    words[0] = 32'h0010_0093; words[1] = 32'h0020_0113; words[2] = 32'h0030_0193;
    imem_req_ready = 1; imem_rsp_valid = 1; inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      imem_rsp_data = words[i];
      vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000 + 32'(4 * i)) begin
        errs++; $display("FAIL zl_req%0d got v=%b a=%h exp 1/%h", i, imem_req_valid, imem_req_addr, 32'h8000_0000 + 32'(4 * i)); end
      tick();
      vecs++; if (imem_rsp_ready !== 1'b1 || imem_req_valid !== 1'b0 || inst_valid !== 1'b0) begin
        errs++; $display("FAIL zl_wait%0d got rr=%b qv=%b iv=%b exp 1/0/0", i, imem_rsp_ready, imem_req_valid, inst_valid); end
      tick();
      vecs++; if (inst_valid !== 1'b1 || inst !== words[i]) begin
        errs++; $display("FAIL zl_hold%0d got iv=%b inst=%h exp 1/%h", i, inst_valid, inst, words[i]); end
      tick();
      vecs++; if (inst_cnt !== 32'(i + 1)) begin
        errs++; $display("FAIL zl_cnt%0d got %0d exp %0d", i, inst_cnt, i + 1); end
    end
    clear_inputs();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_000C || pc !== 32'h8000_000C) begin
        errs++; $display("FAIL bp_req%0d got v=%b a=%h pc=%h exp 1/8000000c", i, imem_req_valid, imem_req_addr, pc); end
    end
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    for (int i = 0; i < 5; i++) begin
      vecs++; if (imem_rsp_ready !== 1'b1 || imem_req_valid !== 1'b0 || pc !== 32'h8000_000C) begin
        errs++; $display("FAIL bp_wait%0d got rr=%b qv=%b pc=%h exp 1/0/8000000c", i, imem_rsp_ready, imem_req_valid, pc); end
      tick();
    end
    imem_rsp_valid = 1; imem_rsp_data = 32'h0040_0213; tick(); imem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (inst_valid !== 1'b1 || inst !== 32'h0040_0213 || pc !== 32'h8000_000C || inst_cnt !== 32'd3 || imem_req_valid !== 1'b0) begin
        errs++; $display("FAIL bp_hold%0d got iv=%b inst=%h pc=%h cnt=%0d qv=%b exp 1/00400213/8000000c/3/0", i, inst_valid, inst, pc, inst_cnt, imem_req_valid); end
      tick();
    end
    inst_ready = 1; tick(); inst_ready = 0;
    vecs++; if (inst_cnt !== 32'd4 || imem_req_addr !== 32'h8000_0010 || inst_valid !== 1'b0) begin
      errs++; $display("FAIL bp_handoff got cnt=%0d a=%h iv=%b exp 4/80000010/0", inst_cnt, imem_req_addr, inst_valid); end
  endtask

  task automatic test_halt();
    do_fetch(32'h0010_0073);
    halt = 1; redirect_valid = 1; redirect_pc = 32'h8000_2000; inst_ready = 1;
    tick();
    clear_inputs();
    vecs++; if ({halted, fault} !== 2'b10 || pc !== 32'h8000_0010 || inst_cnt !== 32'd5) begin
      errs++; $display("FAIL halt_state got h=%b f=%b pc=%h cnt=%0d exp 1/0/80000010/5", halted, fault, pc, inst_cnt); end
    imem_req_ready = 1; imem_rsp_valid = 1; inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++; if ({imem_req_valid, imem_rsp_ready, inst_valid} !== 3'b000 || pc !== 32'h8000_0010) begin
        errs++; $display("FAIL halt_quiet%0d got v=%b pc=%h exp 000/80000010", i, {imem_req_valid, imem_rsp_ready, inst_valid}, pc); end
    end
    clear_inputs();
  endtask

  task automatic test_redirect_wrap();
    rst = 1; tick(); rst = 0;
    do_fetch(32'h0000_0013);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'h8000_1003; tick(); clear_inputs();
    vecs++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_1000 || inst_cnt !== 32'd1) begin
      errs++; $display("FAIL redirect got v=%b a=%h cnt=%0d exp 1/80001000/1", imem_req_valid, imem_req_addr, inst_cnt); end
    do_fetch(32'h0000_0013);
    inst_ready = 1; redirect_valid = 1; redirect_pc = 32'hFFFF_FFFF; tick(); clear_inputs();
    vecs++; if (imem_req_addr !== 32'hFFFF_FFFC) begin
      errs++; $display("FAIL redirect_top got a=%h exp fffffffc", imem_req_addr); end
    do_fetch(32'h0000_0013);
    inst_ready = 1; tick(); clear_inputs();
    vecs++; if (imem_req_addr !== 32'h0000_0000 || pc !== 32'h0 || inst_cnt !== 32'd3) begin
      errs++; $display("FAIL pc_wrap got a=%h pc=%h cnt=%0d exp 0/0/3", imem_req_addr, pc, inst_cnt); end
  endtask

  task automatic test_fault();
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    imem_rsp_valid = 1; imem_rsp_err = 1; imem_rsp_data = 32'hDEAD_BEEF; tick(); clear_inputs();
    vecs++; if ({halted, fault} !== 2'b11 || inst !== 32'h0000_0013 || inst_cnt !== 32'd3) begin
      errs++; $display("FAIL fault_state got h=%b f=%b inst=%h cnt=%0d exp 1/1/00000013/3", halted, fault, inst, inst_cnt); end
    inst_ready = 1;
    for (int i = 0; i < 3; i++) begin
      vecs++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0 || inst_cnt !== 32'd3) begin
        errs++; $display("FAIL fault_quiet%0d got iv=%b qv=%b cnt=%0d exp 0/0/3", i, inst_valid, imem_req_valid, inst_cnt); end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_in_hold();
    rst = 1; tick(); rst = 0;
    vecs++; if ({halted, fault} !== 2'b00) begin
      errs++; $display("FAIL rst_clears_fault got %b exp 00", {halted, fault}); end
    do_fetch(32'h0050_0093);
    vecs++; if (inst_valid !== 1'b1 || inst !== 32'h0050_0093) begin
      errs++; $display("FAIL rh_hold got iv=%b inst=%h exp 1/00500093", inst_valid, inst); end
    rst = 1; tick(); rst = 0; #1;
    vecs++; if (pc !== 32'h8000_0000 || inst_valid !== 1'b0 || inst !== 32'h0 || imem_req_valid !== 1'b1) begin
      errs++; $display("FAIL rh_after got pc=%h iv=%b inst=%h qv=%b exp 80000000/0/0/1", pc, inst_valid, inst, imem_req_valid); end
    imem_rsp_valid = 1; imem_rsp_data = 32'h1234_5678; tick(); imem_rsp_valid = 0;
    vecs++; if (imem_rsp_ready !== 1'b0 || inst_valid !== 1'b0 || inst !== 32'h0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0000) begin
      errs++; $display("FAIL rh_stray got rr=%b iv=%b inst=%h qv=%b a=%h exp 0/0/0/1/80000000", imem_rsp_ready, inst_valid, inst, imem_req_valid, imem_req_addr); end
    imem_req_ready = 1; tick(); imem_req_ready = 0;
    vecs++; if (imem_rsp_ready !== 1'b1 || imem_req_valid !== 1'b0) begin
      errs++; $display("FAIL rh_refetch got rr=%b qv=%b exp 1/0", imem_rsp_ready, imem_req_valid); end
  endtask

  initial begin
    test_reset();
    test_zero_latency();
    test_backpressure();
    test_halt();
    test_redirect_wrap();
    test_fault();
    test_reset_in_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
